snake_seg_decoder: RTL and testbench



---
 rtl/snake_seg_pkg.sv | 25 ++
 rtl/snake_seg_decoder_if.sv | 25 ++
 rtl/snake_frame_lookup.sv | 22 ++
 rtl/snake_seg_decoder.sv | 163 ++++++++++++++++
 tb/tb_snake_seg_decoder.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/snake_seg_pkg.sv
// Shared types and the frame pattern table for the two-digit snake animation
// decoder.
package snake_seg_pkg;

  localparam int NUM_STEPS = 12;

  typedef logic [9:0] frame_t;
  typedef logic [3:0] step_t;

  typedef enum logic {HUNT, LOCKED} state_t;

  // Frame bits are {a,d,e,f,g,a1,b1,c1,d1,g1}, MSB first, indexed by step.
  localparam frame_t PATTERNS [NUM_STEPS] = '{
    10'b0110100000, 10'b0110000010, 10'b0100000110, 10'b0000000111,
    10'b0000100101, 10'b0001100001, 10'b1001100000, 10'b1001010000,
    10'b1000011000, 10'b0000011001, 10'b0000101001, 10'b0010100001
  };

  function automatic step_t succ_step(step_t s, logic rev);
    if (rev)
      return (s == 4'd0) ? step_t'(NUM_STEPS - 1) : s - 4'd1;
    return (s == step_t'(NUM_STEPS - 1)) ? 4'd0 : s + 4'd1;
  endfunction

endpackage

// File: rtl/snake_seg_decoder_if.sv
// Segment lines and decoded status of the snake animation bus; the master side
// drives the segments, the slave side is the decoder.
interface snake_seg_decoder_if import snake_seg_pkg::*; #(parameter int ERR_W = 8);

  logic             a, d, e, f, g;
  logic             a1, b1, c1, d1, g1;
  step_t            step;
  logic             step_strobe;
  logic             locked;
  logic             seq_error;
  logic             stall;
  logic             direction;
  logic [ERR_W-1:0] error_count;

  modport master (
    output a, d, e, f, g, a1, b1, c1, d1, g1,
    input  step, step_strobe, locked, seq_error, stall, direction, error_count
  );

  modport slave (
    input  a, d, e, f, g, a1, b1, c1, d1, g1,
    output step, step_strobe, locked, seq_error, stall, direction, error_count
  );

endinterface

// File: rtl/snake_frame_lookup.sv
// Combinational frame-to-step lookup; legal is low for any pattern outside the
// twelve-entry table.
module snake_frame_lookup
  import snake_seg_pkg::*;
(
  input  frame_t frame,
  output logic   legal,
  output step_t  index
);

  always_comb begin
    legal = 1'b0;
    index = '0;
    for (int i = 0; i < NUM_STEPS; i++) begin
      if (frame == PATTERNS[i]) begin
        legal = 1'b1;
        index = step_t'(i);
      end
    end
  end

endmodule

// File: rtl/snake_seg_decoder.sv
// Snake animation bus monitor: decodes sampled frames, locks onto the cyclic
// step sequence and flags errors and stalls. SNAKE_REVERSE_EN enables reverse lock.
module snake_seg_decoder
  import snake_seg_pkg::*;
#(
  parameter int LOCK_COUNT  = 3,
  parameter int STALL_LIMIT = 1024,
  parameter int ERR_W       = 8
) (
  input  logic               clock,
  input  logic               reset,
  snake_seg_decoder_if.slave bus
);

  localparam int DW = (STALL_LIMIT < 2) ? 1 : $clog2(STALL_LIMIT + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(STALL_LIMIT - 1);
  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

  frame_t           seg_q, seg_prev;
  logic             legal, changed;
  step_t            index;
  state_t           state, state_n;
  step_t            step_q, step_n;
  logic [3:0]       match_q, match_n;
  logic [DW-1:0]    dwell_q, dwell_n;
  logic             strobe_q, strobe_n, err_q, err_n, stall_q, stall_n;
  logic             dir_q, dir_n, hunt_dir_q, hunt_dir_n, locked_q;
  logic [ERR_W-1:0] ecount_q, ecount_n;
  logic             fwd_hit;
`ifdef SNAKE_REVERSE_EN
  logic             rev_hit;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      seg_q    <= '0;
      seg_prev <= '0;
    end else begin
      seg_q    <= {bus.a, bus.d, bus.e, bus.f, bus.g, bus.a1, bus.b1, bus.c1, bus.d1, bus.g1};
      seg_prev <= seg_q;
    end
  end

  snake_frame_lookup u_lookup (
    .frame (seg_q),
    .legal (legal),
    .index (index)
  );

  assign changed = (seg_q != seg_prev);

  always_comb begin
    state_n    = state;
    step_n     = step_q;
    match_n    = match_q;
    dwell_n    = dwell_q;
    strobe_n   = 1'b0;
    err_n      = 1'b0;
    stall_n    = 1'b0;
    dir_n      = dir_q;
    hunt_dir_n = hunt_dir_q;
    ecount_n   = ecount_q;
    fwd_hit    = legal && (index == succ_step(step_q, 1'b0));
`ifdef SNAKE_REVERSE_EN
    rev_hit    = legal && (index == succ_step(step_q, 1'b1));
`endif
    case (state)
      HUNT: begin
        dwell_n = '0;
        if (changed) begin
          if (!legal) begin
            match_n = '0;
          end else begin
            step_n = index;
`ifdef SNAKE_REVERSE_EN
            // The first adjacent pair picks the direction; later frames must follow it.
            if (match_q == 4'd1 && (fwd_hit || rev_hit)) begin
              match_n    = 4'd2;
              hunt_dir_n = rev_hit;
            end else if (match_q >= 4'd2 && (hunt_dir_q ? rev_hit : fwd_hit)) begin
              match_n = match_q + 4'd1;
            end else begin
              match_n    = 4'd1;
              hunt_dir_n = 1'b0;
            end
            if (match_n == LOCK_N) dir_n = hunt_dir_n;
`else
            match_n = fwd_hit ? match_q + 4'd1 : 4'd1;
`endif
            if (match_n == LOCK_N) state_n = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (changed) begin
          if (legal && index == succ_step(step_q, dir_q)) begin
            step_n   = index;
            strobe_n = 1'b1;
            dwell_n  = '0;
          end else begin
            err_n      = 1'b1;
            state_n    = HUNT;
            hunt_dir_n = 1'b0;
            if (ecount_q != '1) ecount_n = ecount_q + 1'b1;
            if (legal) begin
              step_n  = index;
              match_n = 4'd1;
            end else begin
              match_n = '0;
            end
          end
        end else if (STALL_LIMIT != 0) begin
          if (dwell_q == DWELL_LAST) begin
            stall_n = 1'b1;
            state_n = HUNT;
            match_n = '0;
            dwell_n = '0;
          end else begin
            dwell_n = dwell_q + 1'b1;
          end
        end
      end
      default: state_n = HUNT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= HUNT;
      step_q     <= '0;
      match_q    <= '0;
      dwell_q    <= '0;
      strobe_q   <= 1'b0;
      err_q      <= 1'b0;
      stall_q    <= 1'b0;
      dir_q      <= 1'b0;
      hunt_dir_q <= 1'b0;
      ecount_q   <= '0;
      locked_q   <= 1'b0;
    end else begin
      state      <= state_n;
      step_q     <= step_n;
      match_q    <= match_n;
      dwell_q    <= dwell_n;
      strobe_q   <= strobe_n;
      err_q      <= err_n;
      stall_q    <= stall_n;
      dir_q      <= dir_n;
      hunt_dir_q <= hunt_dir_n;
      ecount_q   <= ecount_n;
      locked_q   <= (state_n == LOCKED);
    end
  end

  assign bus.step        = step_q;
  assign bus.step_strobe = strobe_q;
  assign bus.locked      = locked_q;
  assign bus.seq_error   = err_q;
  assign bus.stall       = stall_q;
  assign bus.direction   = dir_q;
  assign bus.error_count = ecount_q;

endmodule

// File: tb/tb_snake_seg_decoder.sv
// Self-checking bench for snake_seg_decoder: directed and random frame streams
// compared every cycle against a behavioural model of the lock/error rules.
module tb_snake_seg_decoder;

  localparam int LOCK  = 3;
  localparam int STALL = 1024;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  snake_seg_decoder_if #(.ERR_W(8)) bus ();

  snake_seg_decoder #(.LOCK_COUNT(LOCK), .STALL_LIMIT(STALL), .ERR_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  bit [9:0] tbl [12] = '{
    10'b0110100000, 10'b0110000010, 10'b0100000110, 10'b0000000111,
    10'b0000100101, 10'b0001100001, 10'b1001100000, 10'b1001010000,
    10'b1000011000, 10'b0000011001, 10'b0000101001, 10'b0010100001
  };

  int nChecks = 0;
  int nPass   = 0;

  logic [9:0] drv, p1, p2;
  int m_locked, m_step, m_match, m_dwell, m_dir, m_hdir, m_err;
  int m_strobe, m_serr, m_stall;
  int lastIdx;
  int stallSeen;

  function automatic int decode(logic [9:0] fr);
    for (int i = 0; i < 12; i++)
      if (tbl[i] == fr) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic applyStimulus(input logic [9:0] fr);
    drv = fr;
    {bus.a, bus.d, bus.e, bus.f, bus.g, bus.a1, bus.b1, bus.c1, bus.d1, bus.g1} = fr;
  endtask

  task automatic modelReset();
    m_locked = 0; m_step = 0; m_match = 0; m_dwell = 0; m_dir = 0; m_hdir = 0;
    m_err = 0; m_strobe = 0; m_serr = 0; m_stall = 0;
    p1 = '0; p2 = '0;
  endtask

  // Evaluates the frame sampled on the previous edge against the one before it.
  task automatic modelStep();
    int idx, fwd, rev;
    bit changed;
    m_strobe = 0; m_serr = 0; m_stall = 0;
    changed = (p1 != p2);
    idx = decode(p1);
    fwd = (m_step + 1) % 12;
    rev = (m_step + 11) % 12;
    if (m_locked == 0) begin
      m_dwell = 0;
      if (changed) begin
        if (idx < 0) m_match = 0;
        else begin
`ifdef SNAKE_REVERSE_EN
          if (m_match == 1 && (idx == fwd || idx == rev)) begin
            m_hdir = (idx == rev) ? 1 : 0;
            m_match = 2;
          end else if (m_match >= 2 && idx == (m_hdir != 0 ? rev : fwd)) m_match++;
          else begin
            m_match = 1;
            m_hdir = 0;
          end
`else
          m_match = (idx == fwd) ? m_match + 1 : 1;
`endif
          m_step = idx;
          if (m_match == LOCK) begin
            m_locked = 1;
            m_dir = m_hdir;
          end
        end
      end
    end else begin
      if (changed) begin
        if (idx >= 0 && idx == (m_dir != 0 ? rev : fwd)) begin
          m_step = idx; m_strobe = 1; m_dwell = 0;
        end else begin
          m_serr = 1; m_locked = 0; m_hdir = 0;
          if (m_err < 255) m_err++;
          if (idx >= 0) begin
            m_step = idx; m_match = 1;
          end else m_match = 0;
        end
      end else begin
        m_dwell++;
        if (m_dwell == STALL) begin
          m_stall = 1; m_locked = 0; m_match = 0; m_dwell = 0;
        end
      end
    end
  endtask

  task automatic checkOutput();
    chk("step", bus.step, m_step);
    chk("step_strobe", bus.step_strobe, m_strobe);
    chk("locked", bus.locked, m_locked);
    chk("seq_error", bus.seq_error, m_serr);
    chk("stall", bus.stall, m_stall);
    chk("direction", bus.direction, m_dir);
    chk("error_count", bus.error_count, m_err);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (reset) modelReset();
    else begin
      modelStep();
      p2 = p1;
      p1 = drv;
    end
    checkOutput();
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus('0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    doReset();

    // Two full forward laps: lock appears two edges after the third frame.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 12; i++) begin
        applyStimulus(tbl[i]);
        tick();
        if (r == 0 && i == 3) chk("lock_rise", bus.locked, 1);
        if (r == 0 && i == 2) chk("pre_lock", bus.locked, 0);
      end
    end
    tick();
    chk("lap_locked", bus.locked, 1);
    chk("lap_step", bus.step, 11);
    chk("lap_errors", bus.error_count, 0);

    // Out-of-sequence frame 9 while locked at step 5, then relock.
    for (int i = 0; i <= 5; i++) begin
      applyStimulus(tbl[i]);
      tick();
    end
    applyStimulus(tbl[9]);
    tick();
    tick();
    chk("oos_error", bus.seq_error, 1);
    chk("oos_count", bus.error_count, 1);
    chk("oos_unlock", bus.locked, 0);
    for (int i = 10; i <= 12; i++) begin
      applyStimulus(tbl[i % 12]);
      tick();
    end
    tick();
    chk("relock", bus.locked, 1);

    // Illegal frame, then the count restarts at 1 on the next legal frame.
    applyStimulus(10'h3FF);
    tick();
    tick();
    chk("illegal_error", bus.seq_error, 1);
    chk("illegal_count", bus.error_count, 2);
    for (int i = 3; i <= 5; i++) begin
      applyStimulus(tbl[i]);
      tick();
      tick();
      chk("illegal_relock", bus.locked, (i == 5) ? 1 : 0);
    end

    // Walk to step 4 and hold it until the stall fires.
    for (int i = 6; i <= 16; i++) begin
      applyStimulus(tbl[i % 12]);
      tick();
    end
    stallSeen = 0;
    for (int n = 0; n < STALL + 8; n++) begin
      tick();
      if (bus.stall === 1'b1) stallSeen++;
    end
    chk("stall_once", stallSeen, 1);
    chk("stall_unlock", bus.locked, 0);
    chk("stall_errors", bus.error_count, 2);

    // Randomized mix of forward steps, holds, jumps, reversals and illegal frames.
    lastIdx = 4;
    for (int n = 0; n < 600; n++) begin
      int r;
      logic [9:0] fr;
      r = $urandom_range(0, 99);
      if (r < 70) begin
        lastIdx = (lastIdx + 1) % 12;
        applyStimulus(tbl[lastIdx]);
      end else if (r < 80) begin
        applyStimulus(drv);
      end else if (r < 88) begin
        lastIdx = $urandom_range(0, 11);
        applyStimulus(tbl[lastIdx]);
      end else if (r < 94) begin
        fr = 10'($urandom);
        if (decode(fr) >= 0) fr = 10'h3FF;
        applyStimulus(fr);
      end else begin
        lastIdx = (lastIdx + 11) % 12;
        applyStimulus(tbl[lastIdx]);
      end
      tick();
    end

    // Force 300 lock/error cycles so the counter saturates.
    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < 3; k++) begin
        lastIdx = (lastIdx + 1) % 12;
        applyStimulus(tbl[lastIdx]);
        tick();
      end
      lastIdx = (lastIdx + 5) % 12;
      applyStimulus(tbl[lastIdx]);
      tick();
    end
    tick();
    chk("saturate", bus.error_count, 255);

    // Reset in the middle of a lock clears everything on the edge.
    for (int k = 0; k < 4; k++) begin
      lastIdx = (lastIdx + 1) % 12;
      applyStimulus(tbl[lastIdx]);
      tick();
    end
    tick();
    chk("pre_reset_lock", bus.locked, 1);
    reset = 1'b1;
    tick();
    chk("reset_locked", bus.locked, 0);
    chk("reset_count", bus.error_count, 0);
    chk("reset_step", bus.step, 0);
    reset = 1'b0;

    // Reverse run 11, 10, 9 then a step back to 10.
    for (int i = 11; i >= 9; i--) begin
      applyStimulus(tbl[i]);
      tick();
    end
    tick();
`ifdef SNAKE_REVERSE_EN
    chk("rev_locked", bus.locked, 1);
    chk("rev_dir", bus.direction, 1);
    applyStimulus(tbl[10]);
    tick();
    tick();
    chk("rev_flip_error", bus.seq_error, 1);
`else
    chk("rev_not_locked", bus.locked, 0);
    chk("rev_dir_tied", bus.direction, 0);
`endif

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
